// File: rtl/pif_rom_ctrl.sv
// pif_rom_ctrl: word-fetch controller and two-port round-robin arbiter for the
// 512-byte PIF boot ROM. Each 32-bit word read is turned into four byte reads
// on the ROM's synchronous port. The bytes are assembled big-endian and the
// granted requester is acknowledged. A lockout returns zero data to masked
// requesters without touching the ROM.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req0/addr0/ack0/data0 requester 0 (PIF MCU): word request, word address,
//                         one-cycle ack, read data held until the next ack
//   req1/addr1/ack1/data1 requester 1 (SI/RCP boot path), same protocol
//   lock                  ROM lockout, sampled at grant
//   rom_address, rom_oe   byte address and output enable to the ROM
//   rom_valid, rom_q      byte valid and data returned one cycle after rom_oe
module pif_rom_ctrl #(
  parameter logic [1:0] LOCK_MASK = 2'b10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [6:0]  addr0,
  output logic        ack0,
  output logic [31:0] data0,
  input  logic        req1,
  input  logic [6:0]  addr1,
  output logic        ack1,
  output logic [31:0] data1,
  input  logic        lock,
  output logic [8:0]  rom_address,
  output logic        rom_oe,
  input  logic        rom_valid,
  input  logic [7:0]  rom_q
);

  localparam int unsigned WORD_W = 7;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BEAT_W = 2;
  localparam int unsigned HOLD_W = DATA_W - BYTE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    LOCKOUT = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                gnt, gnt_nxt;
  logic                last_gnt, last_gnt_nxt;
  logic [WORD_W-1:0]   word, word_nxt;
  logic [BEAT_W-1:0]   issue_cnt, issue_nxt;
  logic [BEAT_W-1:0]   rx_cnt, rx_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic                oe_nxt;
  logic [ADDR_W-1:0]   raddr_nxt;
  logic                ack0_nxt, ack1_nxt;
  logic [DATA_W-1:0]   data0_nxt, data1_nxt;

  // Arbitration: a lone request wins; on contention the one not granted last.
  logic                gnt_sel;
  logic [WORD_W-1:0]   addr_sel;
  assign gnt_sel  = (req0 & req1) ? ~last_gnt : req1;
  assign addr_sel = gnt_sel ? addr1 : addr0;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;  // makes requester 0 win the first contention
      word        <= '0;
      issue_cnt   <= '0;
      rx_cnt      <= '0;
      hold        <= '0;
      rom_oe      <= 1'b0;
      rom_address <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      data0       <= '0;
      data1       <= '0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last_gnt    <= last_gnt_nxt;
      word        <= word_nxt;
      issue_cnt   <= issue_nxt;
      rx_cnt      <= rx_nxt;
      hold        <= hold_nxt;
      rom_oe      <= oe_nxt;
      rom_address <= raddr_nxt;
      ack0        <= ack0_nxt;
      ack1        <= ack1_nxt;
      data0       <= data0_nxt;
      data1       <= data1_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    word_nxt     = word;
    issue_nxt    = issue_cnt;
    rx_nxt       = rx_cnt;
    hold_nxt     = hold;
    oe_nxt       = rom_oe;
    raddr_nxt    = rom_address;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    data0_nxt    = data0;
    data1_nxt    = data1;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_nxt      = gnt_sel;
          last_gnt_nxt = gnt_sel;
          word_nxt     = addr_sel;
          if (lock && LOCK_MASK[gnt_sel]) begin
            state_nxt = LOCKOUT;
          end else begin
            state_nxt = FETCH;
            oe_nxt    = 1'b1;
            raddr_nxt = {addr_sel, 2'b00};
            issue_nxt = '0;
            rx_nxt    = '0;
          end
        end
      end

      FETCH: begin
        // Issue side: step the byte lane each cycle, stop after lane 3.
        if (rom_oe) begin
          if (issue_cnt == 2'd3) begin
            oe_nxt = 1'b0;
          end else begin
            issue_nxt = BEAT_W'(issue_cnt + 2'd1);
            raddr_nxt = {word, BEAT_W'(issue_cnt + 2'd1)};
          end
        end
        // Receive side: shift in the first three bytes, finish on the fourth.
        if (rom_valid) begin
          rx_nxt = BEAT_W'(rx_cnt + 2'd1);
          if (rx_cnt == 2'd3) begin
            if (gnt) begin
              data1_nxt = {hold, rom_q};
              ack1_nxt  = 1'b1;
            end else begin
              data0_nxt = {hold, rom_q};
              ack0_nxt  = 1'b1;
            end
            state_nxt = ACK;
          end else begin
            hold_nxt = {hold[HOLD_W-BYTE_W-1:0], rom_q};
          end
        end
      end

      // Locked requester: zero data, no ROM access.
      LOCKOUT: begin
        if (gnt) begin
          data1_nxt = '0;
          ack1_nxt  = 1'b1;
        end else begin
          data0_nxt = '0;
          ack0_nxt  = 1'b1;
        end
        state_nxt = ACK;
      end

      ACK: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pif_rom_ctrl.sv
// tb_pif_rom_ctrl: directed bench for pif_rom_ctrl with a behavioural
// synchronous ROM (valid and data one cycle after oe).
module tb_pif_rom_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, lock;
  logic [6:0]  addr0, addr1;
  logic        ack0, ack1;
  logic [31:0] data0, data1;
  logic [8:0]  rom_address;
  logic        rom_oe;
  logic        rom_valid = 1'b0;
  logic [7:0]  rom_q = 8'h00;

  logic [7:0]  mem [512];

  int n_assert = 0;
  int n_fail   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int oe_cnt   = 0;

  pif_rom_ctrl #(.LOCK_MASK(2'b10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0       (req0),
    .addr0      (addr0),
    .ack0       (ack0),
    .data0      (data0),
    .req1       (req1),
    .addr1      (addr1),
    .ack1       (ack1),
    .data1      (data1),
    .lock       (lock),
    .rom_address(rom_address),
    .rom_oe     (rom_oe),
    .rom_valid  (rom_valid),
    .rom_q      (rom_q)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model.
  always @(posedge clk) begin
    rom_valid <= rom_oe;
    rom_q     <= mem[rom_address];
  end

  // Event counters, sampled on the rising edge.
  always @(posedge clk) begin
    if (ack0 === 1'b1) ack0_cnt++;
    if (ack1 === 1'b1) ack1_cnt++;
    if (rom_oe === 1'b1) oe_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input bit which, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (((which ? ack1 : ack0) !== 1'b1) && (cycles < budget));
  endtask

  task automatic wait_any(input int budget, output int who, output int cycles);
    cycles = 0;
    who    = -1;
    do begin
      @(negedge clk);
      cycles++;
      if (ack0 === 1'b1) who = 0;
      else if (ack1 === 1'b1) who = 1;
    end while ((who < 0) && (cycles < budget));
  endtask

  initial begin
    int cyc;
    int who;
    int o_snap;
    int a0_snap;
    int a1_snap;

    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; lock = 1'b0;
    addr0 = 7'h00; addr1 = 7'h00;
    for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
    mem[9'h000] = 8'h80; mem[9'h001] = 8'h37; mem[9'h002] = 8'h12; mem[9'h003] = 8'h40;
    mem[9'h004] = 8'hDE; mem[9'h005] = 8'hAD; mem[9'h006] = 8'hBE; mem[9'h007] = 8'hEF;
    mem[9'h1FC] = 8'hCA; mem[9'h1FD] = 8'hFE; mem[9'h1FE] = 8'hF0; mem[9'h1FF] = 8'h0D;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_ack1", 32'(ack1), 0);
    chk("rst_oe", 32'(rom_oe), 0);
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_data0", data0, 0);
    chk("rst_data1", data1, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single unlocked fetch of word 0
    req0 = 1'b1; addr0 = 7'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_oe", 32'(rom_oe), 1);
      chk("t1_addr", 32'(rom_address), 32'(k));
    end
    @(negedge clk);
    chk("t1_oe_drop", 32'(rom_oe), 0);
    chk("t1_ack_early", 32'(ack0), 0);
    @(negedge clk);
    chk("t1_ack", 32'(ack0), 1);
    chk("t1_data0", data0, 32'h80371240);
    chk("t1_data1", data1, 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_ack_end", 32'(ack0), 0);
    chk("t1_data0_hold", data0, 32'h80371240);

    // Contention with round robin; requester 1 reads the top word
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    a0_snap = ack0_cnt; a1_snap = ack1_cnt;
    addr0 = 7'h01; addr1 = 7'h7F; req0 = 1'b1; req1 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      wait_any(20, who, cyc);
      chk("t2_order", 32'(who), 32'(w % 2));
      chk("t2_latency", 32'(cyc), (w == 0) ? 32'd6 : 32'd7);
      if (who == 0) chk("t2_data0", data0, 32'hDEADBEEF);
      else          chk("t2_data1", data1, 32'hCAFEF00D);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_ack0_count", 32'(ack0_cnt - a0_snap), 2);
    chk("t2_ack1_count", 32'(ack1_cnt - a1_snap), 2);
    chk("t2_data0_final", data0, 32'hDEADBEEF);
    chk("t2_data1_final", data1, 32'hCAFEF00D);
    chk("t2_idle_oe", 32'(rom_oe), 0);

    // Lockout: requester 1 gets zero, requester 0 still reads the ROM
    lock = 1'b1;
    o_snap = oe_cnt;
    req1 = 1'b1; addr1 = 7'h00;
    wait_ack(1'b1, 10, cyc);
    chk("t3_lock_latency", 32'(cyc), 2);
    chk("t3_lock_data1", data1, 0);
    chk("t3_lock_data0", data0, 32'hDEADBEEF);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_lock_no_oe", 32'(oe_cnt - o_snap), 0);
    chk("t3_lock_ack_end", 32'(ack1), 0);
    req0 = 1'b1; addr0 = 7'h00;
    wait_ack(1'b0, 20, cyc);
    chk("t3_req0_latency", 32'(cyc), 6);
    chk("t3_req0_data", data0, 32'h80371240);
    req0 = 1'b0;
    lock = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the third issue beat
    req0 = 1'b1; addr0 = 7'h01;
    repeat (3) @(negedge clk);
    chk("t4_third_oe", 32'(rom_oe), 1);
    chk("t4_third_addr", 32'(rom_address), 32'h006);
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("t4_rst_oe", 32'(rom_oe), 0);
    chk("t4_rst_ack", 32'(ack0), 0);
    chk("t4_rst_data0", data0, 0);
    chk("t4_rst_addr", 32'(rom_address), 0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t4_stale_oe", 32'(rom_oe), 0);
    chk("t4_stale_ack", 32'(ack0), 0);
    @(negedge clk);
    req0 = 1'b1; addr0 = 7'h01;
    wait_ack(1'b0, 20, cyc);
    chk("t4_refetch_latency", 32'(cyc), 6);
    chk("t4_refetch_data", data0, 32'hDEADBEEF);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    // Request dropped right after grant
    o_snap = oe_cnt; a0_snap = ack0_cnt;
    req0 = 1'b1; addr0 = 7'h00;
    @(negedge clk);
    req0 = 1'b0;
    chk("t5_granted_oe", 32'(rom_oe), 1);
    wait_ack(1'b0, 20, cyc);
    chk("t5_latency", 32'(cyc), 5);
    chk("t5_data0", data0, 32'h80371240);
    repeat (4) @(negedge clk);
    chk("t5_oe_beats", 32'(oe_cnt - o_snap), 4);
    chk("t5_ack_count", 32'(ack0_cnt - a0_snap), 1);
    chk("t5_no_refetch", 32'(rom_oe), 0);

    // Back-to-back requests
    req0 = 1'b1; addr0 = 7'h01;
    wait_ack(1'b0, 20, cyc);
    chk("t6_first_latency", 32'(cyc), 6);
    chk("t6_first_data", data0, 32'hDEADBEEF);
    req0 = 1'b0;
    @(negedge clk);
    chk("t6_ack_end", 32'(ack0), 0);
    req0 = 1'b1; addr0 = 7'h00;
    @(negedge clk);
    chk("t6_regrant_oe", 32'(rom_oe), 1);
    chk("t6_regrant_addr", 32'(rom_address), 0);
    chk("t6_data_hold", data0, 32'hDEADBEEF);
    wait_ack(1'b0, 20, cyc);
    chk("t6_second_latency", 32'(cyc), 5);
    chk("t6_second_data", data0, 32'h80371240);
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pif_rom_ctrl.md
# pif_rom_ctrl

Word-fetch controller and two-port arbiter for the 512-byte PIF boot ROM. It converts 32-bit word read requests from two requesters into four sequential byte reads on the ROM's synchronous port. Requester 0 is the PIF microcontroller and requester 1 is the SI/RCP boot path. The ROM returns `valid` one cycle after `oe`. The block assembles the four bytes big-endian, acknowledges the winning requester, and enforces the post-boot ROM lockout.

## Interface
- `LOCK_MASK`, default 2'b10: per-requester lockout enable. When `lock` is 1, a requester whose bit is set gets zero data and no ROM access.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0` in 1: requester 0 word request. Must be held until `ack0`, then dropped in the `ack0` cycle.
- `addr0` in 7: requester 0 word address (ROM byte address [8:2]).
- `ack0` out 1: one-cycle pulse; `data0` is valid from this cycle.
- `data0` out 32: requester 0 read data. Held until the next `ack0`.
- `req1`, `addr1`, `ack1`, `data1`: same as above, for requester 1.
- `lock` in 1: ROM lockout, sampled at grant.
- `rom_address` out 9: to ROM `address_a`.
- `rom_oe` out 1: to ROM `oe`.
- `rom_valid` in 1: from ROM `valid`.
- `rom_q` in 8: from ROM `q_a`.

## Operation
- All outputs are registered. Reset values:
  - `ack0`, `ack1`, `rom_oe` = 0
  - `rom_address`, `data0`, `data1` = 0
  - state = IDLE
  - round-robin pointer favours requester 0
- States:
  - IDLE: sample `req0`/`req1`.
    - Single request: grant it.
    - Both requesting: grant the requester not granted last. After reset, requester 0 wins.
    - Record `gnt` and the word address; update the pointer on every grant.
  - Grant to a locked requester (`lock`=1 and `LOCK_MASK[gnt]`=1): go to ACK with data = 32'h0. No ROM access.
  - Other grants: go to FETCH.
    - Issue counter: `rom_oe`=1, `rom_address`={word,2'b00} for the first beat.
    - The low two bits step 00, 01, 10, 11 over four consecutive cycles.
    - `rom_oe` drops after the fourth issue.
  - FETCH, capture:
    - A 2-bit receive counter counts `rom_valid` beats.
    - Beat 0 → [31:24], beat 1 → [23:16], beat 2 → [15:8], beat 3 → [7:0].
    - On the fourth valid beat, load the granted `dataN`, pulse `ackN`, and go to ACK.
  - ACK: one cycle with `ackN`=1; requests are ignored; then go to IDLE.
- Only the granted requester's data register is written. The other requester's data register never changes.
- In IDLE and ACK, `rom_valid` is ignored, so a stale valid after reset has no effect.
- `req` dropped mid-FETCH: the fetch completes and `ack` still pulses.
- `lock` changing mid-FETCH: no effect on the current access.
- Reset mid-fetch: all outputs clear immediately (asynchronous); the partial word is discarded.

## Timing
- Edge E0 = IDLE edge that samples `req` and grants.
- Unlocked fetch:
  - E0: `rom_oe`=1, address=base+0.
  - E1–E3: address base+1 to base+3.
  - E4: `rom_oe`=0.
  - `rom_valid` high after E1 through E4; bytes captured at E2 through E5.
  - `ackN`=1 after E5 (6 edges from grant); `ackN`=0 after E6, state = IDLE.
  - Next grant no earlier than E7, giving 7 cycles per word back-to-back.
- Locked grant: `ackN`=1 after E1; IDLE after E2; next grant at E3.
- No combinational path from any input to any output.

## Test plan
- Reset, then `req0`, `addr0`=7'h00, ROM bytes 0–3 = 80,37,12,40 → `rom_address` 0,1,2,3 on consecutive cycles; `ack0` pulses 6 cycles after grant; `data0`=32'h80371240; `data1` stays 0.
- `req0` and `req1` asserted together and held, with `addr0`=7'h01 and `addr1`=7'h7F → grant order 0,1,0,1. Requester 1 reads bytes 0x1FC–0x1FF (address wrap boundary, no overflow past 0x1FF). Each `ack` occurs once per word.
- `lock`=1, `req1` → `ack1` 2 cycles after request, `data1`=0, `rom_oe` never asserts. `req0` under lock returns real ROM data.
- `reset_n` pulsed low during the third `rom_oe` beat → `rom_oe`/`ack` go to 0 immediately; the following `rom_valid` is ignored; a new `req0` fetches the correct full word.
- `req0` dropped after grant → fetch still completes; `ack0` pulses once; no second fetch is started.
- Back-to-back `req0` re-raised right after `ack0` → second grant at E7; `data0` holds the first word until the second `ack0`.
